// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_4
//  Description : Four-requester round-robin arbiter with bounded grant hold.
//                One owner at a time. The winner is issued as a 2-bit index
//                and as a one-hot grant (the 2-to-4 decode of that index).
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Last hold-count value before the owner must yield to a contender.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q,   idx_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic [3:0]       others;

    // Scan r starting at position p (wrapping mod 4); the first set bit wins.
    // Only called with r != 0, so the fallback value is never used.
    function automatic logic [1:0] pick_idx(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] cand;
        logic [1:0] win;
        logic       found;
        win   = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = p + 2'(k);
            if (!found && r[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // 2-to-4 decode of an owner index into a one-hot grant.
    function automatic logic [3:0] decode_2to4(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Next owner, rotation pointer, hold count and registered grant vector.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = 4'b0000;
        others  = req & ~decode_2to4(idx_q);

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    idx_d   = pick_idx(req, ptr_q);
                    state_d = S_GRANT;
                    cnt_d   = '0;
                    ptr_d   = idx_d + 2'd1;
                end
            end
            S_GRANT: begin
                if (!req[idx_q]) begin
                    // Release wins over timeout; hand off with no idle gap.
                    cnt_d = '0;
                    if (|req) begin
                        idx_d = pick_idx(req, ptr_q);
                        ptr_d = idx_d + 2'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == C_CNT_LAST) begin
                    // Hold budget spent: yield only if someone else is waiting.
                    cnt_d = '0;
                    if (|others) begin
                        idx_d = pick_idx(others, ptr_q);
                        ptr_d = idx_d + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_GRANT) begin
            gnt_d = decode_2to4(idx_d);
        end
    end

    // State register; reset drops any grant and restarts rotation at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == S_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_4
//  Description : Scoreboard bench for rr_arbiter_4. Three instances with
//                HOLD_MAX = 8, 4 and 3. Directed vectors push expected
//                outputs; a negedge monitor pops and compares them, checks
//                grant invariants every cycle, and bounds waiting time
//                under random requests on the HOLD_MAX=3 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

    typedef struct {
        int         due;
        int         which;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       v;
        logic       chk_idx;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a   [3];
    logic [3:0] req_a   [3];
    logic [3:0] gnt_a   [3];
    logic [1:0] idx_a   [3];
    logic       val_a   [3];

    exp_t sb[$];
    exp_t e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   c_on  = 1'b0;
    int   wait_cnt [4];

    always #5 clk = ~clk;

    // Count rising edges; expectations are keyed to this count.
    always @(posedge clk) cyc <= cyc + 1;

    rr_arbiter_4 #(.HOLD_MAX(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst_a[0]), .req(req_a[0]),
        .gnt(gnt_a[0]), .gnt_idx(idx_a[0]), .gnt_valid(val_a[0])
    );
    rr_arbiter_4 #(.HOLD_MAX(4), .CNT_W(3)) u_dut4 (
        .clk(clk), .rst(rst_a[1]), .req(req_a[1]),
        .gnt(gnt_a[1]), .gnt_idx(idx_a[1]), .gnt_valid(val_a[1])
    );
    rr_arbiter_4 #(.HOLD_MAX(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst_a[2]), .req(req_a[2]),
        .gnt(gnt_a[2]), .gnt_idx(idx_a[2]), .gnt_valid(val_a[2])
    );

    // Apply one cycle of stimulus and record the output expected after the next edge.
    task automatic drive(input int w, input logic r, input logic [3:0] rq,
                         input logic [3:0] eg, input logic [1:0] ei, input logic ev,
                         input logic ci, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst_a[w] = r;
        req_a[w] = rq;
        x.due     = cyc + 1;
        x.which   = w;
        x.gnt     = eg;
        x.idx     = ei;
        x.v       = ev;
        x.chk_idx = ci;
        x.name    = nm;
        sb.push_back(x);
    endtask

    // Monitor: invariants, scoreboard pops, and wait bound under random load.
    always @(negedge clk) begin
        for (int w = 0; w < 3; w++) begin
            if (rst_a[w] === 1'b0 || cyc > 1) begin
                total++;
                if ($countones(gnt_a[w]) > 1 ||
                    (val_a[w] ? (gnt_a[w] !== (4'b0001 << idx_a[w])) : (gnt_a[w] !== 4'b0000))) begin
                    bad++;
                    $display("FAIL invariant dut%0d cyc=%0d gnt=%b idx=%0d valid=%b",
                             w, cyc, gnt_a[w], idx_a[w], val_a[w]);
                end
            end
        end
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.due != cyc ||
                gnt_a[e.which] !== e.gnt || val_a[e.which] !== e.v ||
                (e.chk_idx && idx_a[e.which] !== e.idx)) begin
                bad++;
                $display("FAIL %s dut%0d cyc=%0d got gnt=%b idx=%0d valid=%b want gnt=%b idx=%0d valid=%b",
                         e.name, e.which, cyc, gnt_a[e.which], idx_a[e.which], val_a[e.which],
                         e.gnt, e.idx, e.v);
            end
        end
        if (c_on) begin
            for (int i = 0; i < 4; i++) begin
                if (req_a[2][i] && !gnt_a[2][i]) begin
                    wait_cnt[i]++;
                    total++;
                    if (wait_cnt[i] > 10) begin
                        bad++;
                        $display("FAIL wait_bound req%0d cyc=%0d waited=%0d limit=10", i, cyc, wait_cnt[i]);
                        wait_cnt[i] = 0;
                    end
                end else begin
                    wait_cnt[i] = 0;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [3:0] r;
        for (int w = 0; w < 3; w++) begin
            rst_a[w] = 1'b1;
            req_a[w] = 4'b0000;
        end
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

        // HOLD_MAX=8 instance: reset, single requester, handoff, mid-grant reset.
        drive(0, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1, "reset_1");
        drive(0, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1, "reset_2");
        drive(0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, "idle_after_reset");
        drive(0, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, "single_grant");
        repeat (20) drive(0, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, "single_hold");
        drive(0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "single_release");
        drive(0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, "handoff_grant1");
        drive(0, 1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b1, "handoff_hold1");
        drive(0, 1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1, "handoff_to3");
        repeat (5) drive(0, 1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1, "owner3_hold");
        drive(0, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1, "mid_reset");
        drive(0, 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, "post_reset_grant0");
        repeat (7) drive(0, 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, "hold8_owner0");
        drive(0, 1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1, "timeout8_to1");

        // HOLD_MAX=4 instance: fair rotation under full contention.
        drive(1, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1, "rot_reset");
        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1, 1'b0, 4'b1111, 4'(1 << o), 2'(o), 1'b1, 1'b1, "rotation");
            end
        end
        drive(1, 1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, "rotation_wrap");
        repeat (3) drive(1, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, "solo_hold4");
        drive(1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "release_at_limit");

        // HOLD_MAX=3 instance: random sticky requests, wait bound 3*3+1.
        @(posedge clk);
        #1;
        rst_a[2] = 1'b0;
        c_on     = 1'b1;
        repeat (10000) begin
            @(posedge clk);
            #1;
            r = req_a[2];
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            end
            req_a[2] = r;
        end
        c_on = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        bad++;
        $display("FAIL watchdog cyc=%0d limit=300000", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
